// File: rtl/wb_timer_pkg.sv
// Shared definitions for the Wishbone timer array: register map, CTRL layout,
// bus FSM states and the byte-lane merge helper.
package wb_timer_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_CMP    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_DIR    = 1;
  localparam int unsigned CTRL_AUTO   = 2;
  localparam int unsigned CTRL_IRQ_EN = 3;

  // Byte offset of the global prescaler inside the 256-byte window
  localparam logic [7:0] PRESCALE_OFFSET = 8'hF0;

  typedef struct packed {
    logic irq_en;
    logic auto_rl;
    logic dir;
    logic en;
  } ctrl_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } wb_state_e;

  // Replace the byte lanes selected by sel with the matching lanes of new_v
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: up/down counter with compare, auto-reload and sticky flag.
module timer_channel
  import wb_timer_pkg::*;
#(
  parameter int unsigned BITS = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            tick_i,
  input  logic            ctrl_we_i,
  input  ctrl_t           ctrl_wdata_i,
  input  logic            count_we_i,
  input  logic [BITS-1:0] count_wdata_i,
  input  logic            cmp_we_i,
  input  logic [BITS-1:0] cmp_wdata_i,
  input  logic            flag_clr_i,
  output logic [BITS-1:0] count_o,
  output logic [BITS-1:0] cmp_o,
  output ctrl_t           ctrl_o,
  output logic            flag_o
);

  logic [BITS-1:0] count_q, count_d;
  logic [BITS-1:0] cmp_q, cmp_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic            flag_q, flag_d;
  logic            match_c;

  // Next state: counting first, then bus writes override (bus wins, flag set wins)
  always_comb begin
    count_d = count_q;
    cmp_d   = cmp_q;
    ctrl_d  = ctrl_q;
    flag_d  = flag_q;
    match_c = 1'b0;
    if (tick_i && ctrl_q.en) begin
      if (!ctrl_q.dir) begin
        if (count_q == cmp_q) begin
          match_c = 1'b1;
          if (ctrl_q.auto_rl) count_d = '0;
          else                ctrl_d.en = 1'b0;
        end else begin
          count_d = count_q + BITS'(1);
        end
      end else begin
        if (count_q == '0) begin
          match_c = 1'b1;
          if (ctrl_q.auto_rl) count_d = cmp_q;
          else                ctrl_d.en = 1'b0;
        end else begin
          count_d = count_q - BITS'(1);
        end
      end
    end
    if (flag_clr_i) flag_d  = 1'b0;
    if (match_c)    flag_d  = 1'b1;
    if (ctrl_we_i)  ctrl_d  = ctrl_wdata_i;
    if (count_we_i) count_d = count_wdata_i;
    if (cmp_we_i)   cmp_d   = cmp_wdata_i;
  end

  // Channel state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      cmp_q   <= '0;
      ctrl_q  <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      ctrl_q  <= ctrl_d;
      flag_q  <= flag_d;
    end
  end

  assign count_o = count_q;
  assign cmp_o   = cmp_q;
  assign ctrl_o  = ctrl_q;
  assign flag_o  = flag_q;

endmodule

// File: rtl/wb_timer_array.sv
// Multi-channel timer array behind a Wishbone slave port.
// Optional macro TIMER_PRESCALE_EN adds a global 16-bit prescaler at offset 0xF0.
module wb_timer_array
  import wb_timer_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned BITS      = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  input  logic [127:0]             la_data_in,
  input  logic [127:0]             la_oenb,
  output logic [NUM_CH*BITS-1:0]   count_o,
  output logic                     irq_o
);

  wb_state_e       state_q, state_d;
  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic            irq_q, irq_d;

  logic            valid_c, hit_c, ch_ok_c, pre_hit_c, wr_c, ch_wr_c;
  logic [3:0]      ch_c;
  logic [1:0]      reg_c;
  logic            freeze_c, pre_tick_c, tick_c;
  logic [31:0]     rdata_c, pre_rdata_c, m_count_c, m_cmp_c;
  ctrl_t           sel_ctrl_c, ctrl_wdata_c;
  logic [BITS-1:0] sel_count_c, sel_cmp_c;
  logic            sel_flag_c;
  logic            unused_ok_c;

  ctrl_t           ctrl_w  [NUM_CH];
  logic [BITS-1:0] count_w [NUM_CH];
  logic [BITS-1:0] cmp_w   [NUM_CH];
  logic [NUM_CH-1:0] flag_w, irq_src_c;

  // Address decode and write qualification (one write per accepted transfer)
  assign valid_c   = wbs_cyc_i & wbs_stb_i;
  assign hit_c     = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign ch_c      = wbs_adr_i[7:4];
  assign reg_c     = wbs_adr_i[3:2];
  assign ch_ok_c   = hit_c && (32'(ch_c) < NUM_CH);
  assign pre_hit_c = hit_c && (wbs_adr_i[7:2] == PRESCALE_OFFSET[7:2]);
  assign wr_c      = valid_c && (state_q == ST_IDLE) && wbs_we_i;
  assign ch_wr_c   = wr_c && ch_ok_c;

  // Debug freeze from the logic analyser; tick is a global enable gated per channel by EN
  assign freeze_c  = ~la_oenb[64] & la_data_in[64];
  assign tick_c    = ~freeze_c & pre_tick_c;

`ifdef TIMER_PRESCALE_EN
  localparam int unsigned PRE_W = 16;
  logic [PRE_W-1:0] pre_q, pre_d, div_q, div_d;
  logic             pre_wr_c;

  assign pre_wr_c    = wr_c && pre_hit_c;
  assign pre_tick_c  = (div_q == pre_q);
  assign pre_rdata_c = 32'(pre_q);

  // Divider: pulse every PRESCALE+1 cycles, restarted by a PRESCALE write
  always_comb begin
    pre_d = pre_q;
    div_d = pre_tick_c ? '0 : div_q + PRE_W'(1);
    if (pre_wr_c) begin
      if (wbs_sel_i[0]) pre_d[7:0]  = wbs_dat_i[7:0];
      if (wbs_sel_i[1]) pre_d[15:8] = wbs_dat_i[15:8];
      div_d = '0;
    end
  end

  // Prescaler registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      pre_q <= '0;
      div_q <= '0;
    end else begin
      pre_q <= pre_d;
      div_q <= div_d;
    end
  end
`else
  assign pre_tick_c  = 1'b1;
  assign pre_rdata_c = '0;
`endif

  // Current values of the addressed channel (old values for read and lane merge)
  always_comb begin
    sel_ctrl_c  = '0;
    sel_count_c = '0;
    sel_cmp_c   = '0;
    sel_flag_c  = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_c == 4'(i)) begin
        sel_ctrl_c  = ctrl_w[i];
        sel_count_c = count_w[i];
        sel_cmp_c   = cmp_w[i];
        sel_flag_c  = flag_w[i];
      end
    end
  end

  // Byte-lane merged write data; CTRL lives entirely in lane 0
  assign m_count_c = merge_bytes(32'(sel_count_c), wbs_dat_i, wbs_sel_i);
  assign m_cmp_c   = merge_bytes(32'(sel_cmp_c), wbs_dat_i, wbs_sel_i);
  always_comb begin
    ctrl_wdata_c = sel_ctrl_c;
    if (wbs_sel_i[0]) begin
      ctrl_wdata_c.en      = wbs_dat_i[CTRL_EN];
      ctrl_wdata_c.dir     = wbs_dat_i[CTRL_DIR];
      ctrl_wdata_c.auto_rl = wbs_dat_i[CTRL_AUTO];
      ctrl_wdata_c.irq_en  = wbs_dat_i[CTRL_IRQ_EN];
    end
  end

  // Read mux; unmapped addresses read as zero
  always_comb begin
    rdata_c = '0;
    if (ch_ok_c) begin
      case (reg_c)
        REG_CTRL: begin
          rdata_c[CTRL_EN]     = sel_ctrl_c.en;
          rdata_c[CTRL_DIR]    = sel_ctrl_c.dir;
          rdata_c[CTRL_AUTO]   = sel_ctrl_c.auto_rl;
          rdata_c[CTRL_IRQ_EN] = sel_ctrl_c.irq_en;
        end
        REG_COUNT:  rdata_c    = 32'(sel_count_c);
        REG_CMP:    rdata_c    = 32'(sel_cmp_c);
        REG_STATUS: rdata_c[0] = sel_flag_c;
        default:    rdata_c    = '0;
      endcase
    end else if (pre_hit_c) begin
      rdata_c = pre_rdata_c;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_sel_c;
    assign ch_sel_c = ch_wr_c && (ch_c == 4'(i));

    timer_channel #(.BITS(BITS)) u_ch (
      .clk_i        (wb_clk_i),
      .rst_ni       (wb_rst_ni),
      .tick_i       (tick_c),
      .ctrl_we_i    (ch_sel_c && (reg_c == REG_CTRL)),
      .ctrl_wdata_i (ctrl_wdata_c),
      .count_we_i   (ch_sel_c && (reg_c == REG_COUNT)),
      .count_wdata_i(m_count_c[BITS-1:0]),
      .cmp_we_i     (ch_sel_c && (reg_c == REG_CMP)),
      .cmp_wdata_i  (m_cmp_c[BITS-1:0]),
      .flag_clr_i   (ch_sel_c && (reg_c == REG_STATUS) && wbs_sel_i[0] && wbs_dat_i[0]),
      .count_o      (count_w[i]),
      .cmp_o        (cmp_w[i]),
      .ctrl_o       (ctrl_w[i]),
      .flag_o       (flag_w[i])
    );

    assign count_o[i*BITS +: BITS] = count_w[i];
    assign irq_src_c[i]            = flag_w[i] & ctrl_w[i].irq_en;
  end

  // Ack FSM: single-cycle ack one cycle after valid, then at least one idle cycle
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    dat_d   = '0;
    irq_d   = |irq_src_c;
    case (state_q)
      ST_IDLE: begin
        if (valid_c) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          dat_d   = rdata_c;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus and interrupt output registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      irq_q   <= irq_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq_o     = irq_q;

  // LA bits other than 64, the byte offset and unused merge lanes are intentionally ignored
  assign unused_ok_c = ^{la_data_in, la_oenb, wbs_adr_i[1:0], m_count_c, m_cmp_c};

endmodule

// File: doc/wb_timer_array.md
Name: wb_timer_array

Overview:
Parametrised multi-channel timer/counter with a Wishbone slave register interface, replacing the single free-running 32-bit counter in the user project area.
- Each channel has up/down counting, compare match, auto-reload, a sticky match flag and an interrupt contribution.
- Logic-analyzer probes can freeze all channels for debug.
- Count values are exported for IO/LA observation.
- Sits directly behind the Caravel Wishbone port at user address space 0x3000_0000.

Parameters:
- NUM_CH, 4, number of independent channels (1..8)
- BITS, 32, counter/compare width per channel (8..32)
- BASE_ADDR, 32'h3000_0000, Wishbone base address; decode on adr[31:8]

Ports:
- wb_clk_i  input  1  clock
- wb_rst_ni  input  1  asynchronous active-low reset
- wbs_stb_i  input  1  Wishbone strobe
- wbs_cyc_i  input  1  Wishbone cycle
- wbs_we_i  input  1  write enable
- wbs_sel_i  input  4  byte selects
- wbs_adr_i  input  32  byte address
- wbs_dat_i  input  32  write data
- wbs_ack_o  output  1  acknowledge
- wbs_dat_o  output  32  read data
- la_data_in  input  128  LA data; bit 64 = freeze request
- la_oenb  input  128  LA output-enable (active-low); bit 64 gates freeze
- count_o  output  NUM_CH*BITS  flattened channel counts; channel 0 in LSBs
- irq_o  output  1  OR of (flag & irq_en) over all channels

Behaviour:
Address decode:
- Hit when adr[31:8]==BASE_ADDR[31:8].
- Channel = adr[7:4]; register = adr[3:2].
- Register 0 CTRL: bit0 EN, bit1 DIR (0 up, 1 down), bit2 AUTO, bit3 IRQ_EN.
- Register 1 COUNT.
- Register 2 CMP.
- Register 3 STATUS: bit0 FLAG, write-1-to-clear.
- Channel >= NUM_CH or missed decode: reads return 0, writes are ignored, ack is still returned.

Handshake:
- valid = cyc & stb.
- ack is asserted exactly one cycle after valid is first seen, for one cycle; then low for at least one cycle.
- Back-to-back transfers therefore take 2 cycles each.
- Read data is registered alongside ack.
- wbs_sel_i byte lanes apply to writes; fields narrower than the lane are truncated to BITS.

Tick:
- tick = EN & ~freeze.
- freeze = ~la_oenb[64] & la_data_in[64].

Counting:
- Up mode: count+1 each tick.
- When count==CMP on a tick: FLAG<=1.
  - AUTO=1: count<=0.
  - AUTO=0: count holds at CMP and EN<=0.
- Down mode: count-1 each tick.
- When count==0 on a tick: FLAG<=1.
  - AUTO=1: count<=CMP.
  - AUTO=0: count holds at 0 and EN<=0.
- Arithmetic is modulo 2^BITS.
- CMP=0 in up mode matches every tick.

Simultaneous events:
- Bus write to COUNT or CTRL in the same cycle as a tick: the bus write wins.
- W1C of FLAG in the same cycle as a new match: set wins (FLAG stays 1).
- Write to CMP takes effect for the comparison in the next cycle.

Reset:
- Async assertion clears all CTRL, COUNT, CMP and FLAG registers.
- Reset values: wbs_ack_o=0, wbs_dat_o=0, count_o=0, irq_o=0.
- Deassertion is synchronised externally.
- Reset mid-transaction drops ack; the master retries.

irq_o is registered: one cycle after FLAG rises.

Optional Feature:
TIMER_PRESCALE_EN.
- When defined: each channel gains register 2 bits [BITS-1:16]... no. Instead, a global PRESCALE register sits at channel offset 0xF0 (16-bit).
  - An internal divider generates a tick enable every PRESCALE+1 cycles.
  - Channel ticks require EN & ~freeze & prescale_tick.
  - The divider resets to 0 on write.
- When undefined: the prescale tick is constantly 1, address 0xF0 reads 0, and no divider logic exists.

Decomposition:
- Package wb_timer_pkg holds:
  - Register offsets REG_CTRL/REG_COUNT/REG_CMP/REG_STATUS.
  - CTRL bit indices.
  - Typedef ctrl_t (packed EN/DIR/AUTO/IRQ_EN).
  - PRESCALE_OFFSET.
- Sub-module timer_channel, instantiated NUM_CH times via generate:
  - Inputs: tick, write strobes/data per register.
  - Outputs: count, cmp, ctrl, flag.
- The top level holds the Wishbone decode, ack FSM (IDLE/ACK), read mux, freeze/prescale and the irq OR.

Test Plan:
- Reset held low, then released → all registers read 0, irq_o=0, ack returns one cycle after valid on every access.
- Ch0: CMP=5, CTRL=EN|AUTO|IRQ_EN → count runs 0..5,0,1...; FLAG=1 after 6 ticks; irq_o high one cycle later; W1C STATUS=1 clears FLAG and irq.
- Ch1: DIR=1, CMP=3, COUNT=3, EN with AUTO=0 → 3,2,1,0, then holds 0; EN reads back 0; FLAG=1.
- Freeze via la_oenb[64]=0, la_data_in[64]=1 for 10 cycles → counts unchanged; after release, counting resumes from the same value.
- Write COUNT=0x100 with sel=4'b0010 in the same cycle a tick occurs → COUNT reads 0x00000100 | (old[7:0] preserved in lane 0 only); bus write wins over the increment. Access to channel 7 with NUM_CH=4 → reads 0, ack is still returned.
- With TIMER_PRESCALE_EN, PRESCALE=3 → channel increments once every 4 cycles.
